// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: parallel word in over valid/ready, shifted out as
// start(0), data LSB-first, parity, stop(1); line idles high.
module serial_frame_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_bit,
  output logic                  ser_valid,
  output logic                  bit_strobe,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  parity_q, parity_d;
  logic                  in_ready_d, ser_bit_d, ser_valid_d, bit_strobe_d, frame_done_d;
  logic                  wrap;

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      in_ready   <= 1'b0;
      ser_bit    <= 1'b1;
      ser_valid  <= 1'b0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      in_ready   <= in_ready_d;
      ser_bit    <= ser_bit_d;
      ser_valid  <= ser_valid_d;
      bit_strobe <= bit_strobe_d;
      frame_done <= frame_done_d;
    end
  end

  // Next state; outputs are derived from the next state so they register in step.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    parity_d     = parity_q;
    frame_done_d = 1'b0;
    wrap         = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d  = S_START;
          shreg_d  = in_data;
          parity_d = (^in_data) ^ PARITY_ODD;
          cnt_d    = '0;
          idx_d    = '0;
        end
      end
      S_START: begin
        if (wrap) state_d = S_DATA;
      end
      S_DATA: begin
        if (wrap) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_PARITY;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (wrap) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    in_ready_d   = (state_d == S_IDLE);
    ser_valid_d  = (state_d != S_IDLE);
    bit_strobe_d = ser_valid_d && (cnt_d == '0);
    case (state_d)
      S_START:  ser_bit_d = 1'b0;
      S_DATA:   ser_bit_d = shreg_d[0];
      S_PARITY: ser_bit_d = parity_d;
      default:  ser_bit_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (BIT_CYCLES=1 even parity, BIT_CYCLES=4
// odd parity) checked cycle by cycle against an expected-frame model.
module tb_serial_frame_tx;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b1;
  logic [7:0] in_data  = '0;
  logic       in_valid = 1'b0;
  logic       sel      = 1'b0;

  logic in_ready0, ser_bit0, ser_valid0, bit_strobe0, frame_done0;
  logic in_ready1, ser_bit1, ser_valid1, bit_strobe1, frame_done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  serial_frame_tx #(.DATA_WIDTH(8), .BIT_CYCLES(1), .PARITY_ODD(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid && !sel),
    .in_ready(in_ready0), .ser_bit(ser_bit0), .ser_valid(ser_valid0),
    .bit_strobe(bit_strobe0), .frame_done(frame_done0)
  );

  serial_frame_tx #(.DATA_WIDTH(8), .BIT_CYCLES(4), .PARITY_ODD(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid && sel),
    .in_ready(in_ready1), .ser_bit(ser_bit1), .ser_valid(ser_valid1),
    .bit_strobe(bit_strobe1), .frame_done(frame_done1)
  );

  // Observed vector: {ser_bit, ser_valid, bit_strobe, in_ready, frame_done}
  function automatic logic [4:0] obs();
    if (sel) return {ser_bit1, ser_valid1, bit_strobe1, in_ready1, frame_done1};
    return {ser_bit0, ser_valid0, bit_strobe0, in_ready0, frame_done0};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expects the handshake for w at the next edge; checks the whole frame and the done cycle.
  task automatic run_frame(input logic [7:0] w, input bit chain, input logic [7:0] next_w);
    int          bc;
    int          strobes;
    int          valids;
    logic [10:0] fbits;
    logic [4:0]  o;
    logic [4:0]  e;
    bc      = sel ? 4 : 1;
    strobes = 0;
    valids  = 0;
    fbits   = {1'b1, (^w) ^ sel, w, 1'b0};
    for (int c = 0; c < 11 * bc; c++) begin
      @(posedge clock); #1;
      o = obs();
      e = {fbits[c / bc], 1'b1, (c % bc) == 0, 1'b0, 1'b0};
      check_eq($sformatf("frame %02h sel%0d cyc %0d", w, sel, c), 32'(o), 32'(e));
      strobes += int'(o[2]);
      valids  += int'(o[3]);
      if (c == 11 * bc - 1) begin
        in_valid = chain;
        in_data  = next_w;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = (w == 8'h00) ? 8'hFF : 8'($urandom);
      end
    end
    check_eq($sformatf("strobes %02h", w), 32'(strobes), 32'd11);
    check_eq($sformatf("valid cycles %02h", w), 32'(valids), 32'(11 * bc));
    @(posedge clock); #1;
    check_eq($sformatf("done %02h", w), 32'(obs()), 32'b10011);
  endtask

  task automatic idle_then_send(input logic [7:0] w);
    int n;
    in_valid = 1'b0;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      check_eq("idle", 32'(obs()), 32'b10010);
    end
    in_data  = w;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] nw;
    bit         ch;

    #1 reset_n = 1'b0;
    #1;
    sel = 1'b0; check_eq("reset sel0", 32'(obs()), 32'b10000);
    sel = 1'b1; check_eq("reset sel1", 32'(obs()), 32'b10000);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    sel = 1'b0; check_eq("held low until edge", 32'(obs()), 32'b10000);
    @(posedge clock); #1;
    check_eq("ready after reset sel0", 32'(obs()), 32'b10010);
    sel = 1'b1; check_eq("ready after reset sel1", 32'(obs()), 32'b10010);

    // BIT_CYCLES=1, even parity
    sel = 1'b0;
    idle_then_send(8'hA5); run_frame(8'hA5, 1'b0, 8'h00);
    idle_then_send(8'h07); run_frame(8'h07, 1'b0, 8'h00);
    idle_then_send(8'h11); run_frame(8'h11, 1'b1, 8'h22);
    run_frame(8'h22, 1'b0, 8'h00);
    idle_then_send(8'h00); run_frame(8'h00, 1'b0, 8'h00);
    idle_then_send(8'hFF); run_frame(8'hFF, 1'b0, 8'h00);
    w = 8'($urandom);
    idle_then_send(w);
    for (int i = 0; i < 10; i++) begin
      ch = 1'($urandom_range(0, 1));
      nw = 8'($urandom);
      run_frame(w, ch, nw);
      if (!ch) idle_then_send(nw);
      w = nw;
    end
    run_frame(w, 1'b0, 8'h00);

    // BIT_CYCLES=4, odd parity
    in_valid = 1'b0;
    @(posedge clock); #1;
    sel = 1'b1;
    idle_then_send(8'h80); run_frame(8'h80, 1'b0, 8'h00);
    idle_then_send(8'h07); run_frame(8'h07, 1'b1, 8'hC3);
    run_frame(8'hC3, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      idle_then_send(w);
      run_frame(w, 1'b0, 8'h00);
    end

    // Reset during DATA bit 3 (cycles 16..19 of a 4-cycle-per-bit frame)
    idle_then_send(8'h5A);
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (17) @(posedge clock);
    #1;
    check_eq("pre-abort bit3", 32'(obs()), 32'b11000);
    #2 reset_n = 1'b0;
    #1 check_eq("abort immediate", 32'(obs()), 32'b10000);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    check_eq("ready after abort", 32'(obs()), 32'b10010);
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      check_eq("no resume", 32'(obs()), 32'b10010);
    end
    idle_then_send(8'h3C); run_frame(8'h3C, 1'b0, 8'h00);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
